// File: rtl/lq_agen_pkg.sv
// Shared definitions for the load/store queue AGEN effective-address pipe.
// Holds the datapath geometry, the itag width, the EX1 register bundle and
// a byte-extraction helper that hides the big-endian byte numbering.
package lq_agen_pkg;

  localparam int unsigned LQ_AGEN_BYTES    = 8;
  localparam int unsigned LQ_AGEN_EA_WIDTH = 64;
  localparam int unsigned LQ_AGEN_ITAG_WIDTH = 7;

  // EX1 register bundle; array index i is architectural byte i (byte 0 = MSB)
  typedef struct packed {
    logic [LQ_AGEN_BYTES-1:0][7:0]   s0;
    logic [LQ_AGEN_BYTES-1:0][7:0]   s1;
    logic [LQ_AGEN_BYTES-1:0]        g;
    logic [LQ_AGEN_BYTES-1:0]        p;
    logic                            cm;
    logic [LQ_AGEN_ITAG_WIDTH-1:0]   itag;
  } lq_agen_ex1_t;

  // Architectural byte i of a 64-bit word held as [63:0]; byte 0 is bits 63:56
  function automatic logic [7:0] lq_agen_byte(input logic [LQ_AGEN_EA_WIDTH-1:0] word,
                                              input int unsigned idx);
    return word[(LQ_AGEN_BYTES - 1 - idx) * 8 +: 8];
  endfunction

endpackage

// File: rtl/lq_agen_csmux.sv
// Byte carry-select mux for the AGEN path.
// Ports:
//   sum0  in  8  byte sum assuming carry-in 0
//   sum1  in  8  byte sum assuming carry-in 1
//   ci_b  in  1  active-low carry into this byte
//   res_c out 8  selected byte (combinational)
module lq_agen_csmux (
  input  logic [7:0] sum0,
  input  logic [7:0] sum1,
  input  logic       ci_b,
  output logic [7:0] res_c
);

  assign res_c = ci_b ? sum0 : sum1;

endmodule

// File: rtl/lq_agen_ea_pipe.sv
// Two-stage pipelined effective-address generator.
// EX0 -> EX1 registers per-byte conditional sums and byte generate/propagate;
// EX1 -> EX2 resolves the inter-byte carries and selects each byte.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ex0_vld/ex0_rdy     EX0 handshake (ex0_rdy = ~ex2_hold, combinational)
//   ex0_base/ex0_offset 64-bit operands, ex0_cm (1 = 64-bit mode), ex0_itag
//   ex2_hold            downstream stall, freezes EX1 and EX2
//   flush               kills all in-flight ops
//   ex2_vld/ex2_ea/ex2_itag/ex2_co64/ex2_co32  registered EX2 results
module lq_agen_ea_pipe
  import lq_agen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex0_vld,
  output logic        ex0_rdy,
  input  logic [63:0] ex0_base,
  input  logic [63:0] ex0_offset,
  input  logic        ex0_cm,
  input  logic [6:0]  ex0_itag,
  input  logic        ex2_hold,
  input  logic        flush,
  output logic        ex2_vld,
  output logic [63:0] ex2_ea,
  output logic [6:0]  ex2_itag,
  output logic        ex2_co64,
  output logic        ex2_co32
);

  lq_agen_ex1_t                 ex0_bundle;
  lq_agen_ex1_t                 ex1_q;
  logic                         ex1_vld;
  logic                         accept;
  logic [LQ_AGEN_BYTES-1:0]     carry;
  logic                         co64_c;
  logic                         co32_c;
  logic [LQ_AGEN_BYTES-1:0][7:0] sel_byte;
  logic [LQ_AGEN_EA_WIDTH-1:0]  ea_c;

  assign ex0_rdy = ~ex2_hold;
  assign accept  = ex0_vld & ~ex2_hold & ~flush;

  // EX0: per-byte conditional sums; p is taken on the sum so g and p never overlap
  always_comb begin
    logic [8:0] sum9;
    ex0_bundle = '0;
    sum9       = '0;
    for (int unsigned i = 0; i < LQ_AGEN_BYTES; i++) begin
      sum9 = {1'b0, lq_agen_byte(ex0_base, i)} + {1'b0, lq_agen_byte(ex0_offset, i)};
      ex0_bundle.s0[i] = sum9[7:0];
      ex0_bundle.s1[i] = sum9[7:0] + 8'd1;
      ex0_bundle.g[i]  = sum9[8];
      ex0_bundle.p[i]  = (sum9[7:0] == 8'hFF);
    end
    ex0_bundle.cm   = ex0_cm;
    ex0_bundle.itag = ex0_itag;
  end

  // EX1 register: flush beats hold, hold freezes, otherwise load on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      ex1_vld <= 1'b0;
      ex1_q   <= '0;
    end else if (flush) begin
      ex1_vld <= 1'b0;
    end else if (!ex2_hold) begin
      ex1_vld <= accept;
      if (accept) begin
        ex1_q <= ex0_bundle;
      end
    end
  end

  // EX1: ripple carries from byte 7 (LSB) up to byte 0; a local running carry
  // keeps the chain free of self-referencing vector bits
  always_comb begin
    logic cin;
    carry = '0;
    cin   = 1'b0;
    for (int i = LQ_AGEN_BYTES - 1; i >= 0; i--) begin
      carry[i] = cin;
      cin      = ex1_q.g[i] | (ex1_q.p[i] & cin);
    end
    co64_c = cin;
    co32_c = carry[3];
  end

  // EX1: one carry-select mux per byte
  for (genvar gi = 0; gi < LQ_AGEN_BYTES; gi++) begin : g_csmux
    lq_agen_csmux u_csmux (
      .sum0  (ex1_q.s0[gi]),
      .sum1  (ex1_q.s1[gi]),
      .ci_b  (~carry[gi]),
      .res_c (sel_byte[gi])
    );
  end

  // Reassemble bytes into the big-endian word; 32-bit mode clears the upper word
  always_comb begin
    ea_c = '0;
    for (int unsigned i = 0; i < LQ_AGEN_BYTES; i++) begin
      ea_c[(LQ_AGEN_BYTES - 1 - i) * 8 +: 8] = sel_byte[i];
    end
    if (!ex1_q.cm) begin
      ea_c[63:32] = 32'h0;
    end
  end

  // EX2 register
  always_ff @(posedge clk) begin
    if (rst) begin
      ex2_vld  <= 1'b0;
      ex2_ea   <= '0;
      ex2_itag <= '0;
      ex2_co64 <= 1'b0;
      ex2_co32 <= 1'b0;
    end else if (flush) begin
      ex2_vld <= 1'b0;
    end else if (!ex2_hold) begin
      ex2_vld  <= ex1_vld;
      ex2_ea   <= ea_c;
      ex2_itag <= ex1_q.itag;
      ex2_co64 <= co64_c;
      ex2_co32 <= co32_c;
    end
  end

endmodule

// File: tb/tb_lq_agen_ea_pipe.sv
// Directed bench for lq_agen_ea_pipe with hand-computed expected values.
module tb_lq_agen_ea_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex0_vld;
  logic        ex0_rdy;
  logic [63:0] ex0_base;
  logic [63:0] ex0_offset;
  logic        ex0_cm;
  logic [6:0]  ex0_itag;
  logic        ex2_hold;
  logic        flush;
  logic        ex2_vld;
  logic [63:0] ex2_ea;
  logic [6:0]  ex2_itag;
  logic        ex2_co64;
  logic        ex2_co32;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lq_agen_ea_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .ex0_vld    (ex0_vld),
    .ex0_rdy    (ex0_rdy),
    .ex0_base   (ex0_base),
    .ex0_offset (ex0_offset),
    .ex0_cm     (ex0_cm),
    .ex0_itag   (ex0_itag),
    .ex2_hold   (ex2_hold),
    .flush      (flush),
    .ex2_vld    (ex2_vld),
    .ex2_ea     (ex2_ea),
    .ex2_itag   (ex2_itag),
    .ex2_co64   (ex2_co64),
    .ex2_co32   (ex2_co32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [63:0] b, input logic [63:0] o, input logic cm,
                         input logic [6:0] itag);
    ex0_vld    = 1'b1;
    ex0_base   = b;
    ex0_offset = o;
    ex0_cm     = cm;
    ex0_itag   = itag;
  endtask

  // single op through an empty pipe: not visible after one edge, visible after two
  task automatic run_op(input string tag, input logic [63:0] b, input logic [63:0] o,
                        input logic cm, input logic [6:0] itag, input logic [63:0] ea,
                        input logic co64, input logic co32);
    present(b, o, cm, itag);
    tick();
    ex0_vld = 1'b0;
    check({tag, "_lat_vld"}, 64'(ex2_vld), 64'd0);
    tick();
    check({tag, "_vld"},  64'(ex2_vld),  64'd1);
    check({tag, "_ea"},   ex2_ea,        ea);
    check({tag, "_itag"}, 64'(ex2_itag), 64'(itag));
    check({tag, "_co64"}, 64'(ex2_co64), 64'(co64));
    check({tag, "_co32"}, 64'(ex2_co32), 64'(co32));
    tick();
    check({tag, "_drain"}, 64'(ex2_vld), 64'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_vld"},  64'(ex2_vld),  64'd0);
    check({tag, "_ea"},   ex2_ea,        64'd0);
    check({tag, "_itag"}, 64'(ex2_itag), 64'd0);
    check({tag, "_co64"}, 64'(ex2_co64), 64'd0);
    check({tag, "_co32"}, 64'(ex2_co32), 64'd0);
  endtask

  initial begin
    rst = 1'b1; ex0_vld = 1'b0; ex0_base = '0; ex0_offset = '0; ex0_cm = 1'b1;
    ex0_itag = '0; ex2_hold = 1'b0; flush = 1'b0;

    // reset state and combinational ready during reset
    tick();
    tick();
    check_zero_outputs("rst");
    check("rst_rdy", 64'(ex0_rdy), 64'd1);
    ex2_hold = 1'b1;
    #1;
    check("rst_rdy_hold", 64'(ex0_rdy), 64'd0);
    ex2_hold = 1'b0;
    rst = 1'b0;
    tick();

    // datapath vectors
    run_op("ripple", 64'h0000_0000_0000_00FF, 64'h1, 1'b1, 7'd5,
           64'h0000_0000_0000_0100, 1'b0, 1'b0);
    run_op("fullprop", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 7'd6,
           64'h0, 1'b1, 1'b1);
    run_op("mode32", 64'h1234_5678_FFFF_FFFF, 64'h1, 1'b0, 7'd7,
           64'h0, 1'b0, 1'b1);
    run_op("plain64", 64'h1234_5678_0000_0010, 64'h20, 1'b1, 7'd8,
           64'h1234_5678_0000_0030, 1'b0, 1'b0);
    run_op("gp_chain", 64'h7F80, 64'h7F80, 1'b1, 7'd9,
           64'hFF00, 1'b0, 1'b0);
    run_op("co64_only", 64'hFF00_0000_0000_0000, 64'h0100_0000_0000_0000, 1'b1, 7'd10,
           64'h0, 1'b1, 1'b0);

    // hold: itags 1,2,3 back-to-back, hold 3 cycles while itag 1 sits in EX2
    present(64'h10, 64'h1, 1'b1, 7'd1);
    tick();
    present(64'h20, 64'h1, 1'b1, 7'd2);
    tick();
    check("hold_pre_itag", 64'(ex2_itag), 64'd1);
    present(64'h30, 64'h1, 1'b1, 7'd3);
    ex2_hold = 1'b1;
    #1;
    check("hold_rdy0", 64'(ex0_rdy), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold_c%0d_vld", k),  64'(ex2_vld),  64'd1);
      check($sformatf("hold_c%0d_itag", k), 64'(ex2_itag), 64'd1);
      check($sformatf("hold_c%0d_ea", k),   ex2_ea,        64'h11);
      check($sformatf("hold_c%0d_rdy", k),  64'(ex0_rdy),  64'(k == 2 ? 0 : 0));
    end
    ex2_hold = 1'b0;
    tick();
    ex0_vld = 1'b0;
    check("hold_op2_vld",  64'(ex2_vld),  64'd1);
    check("hold_op2_itag", 64'(ex2_itag), 64'd2);
    check("hold_op2_ea",   ex2_ea,        64'h21);
    tick();
    check("hold_op3_vld",  64'(ex2_vld),  64'd1);
    check("hold_op3_itag", 64'(ex2_itag), 64'd3);
    check("hold_op3_ea",   ex2_ea,        64'h31);
    tick();
    check("hold_empty", 64'(ex2_vld), 64'd0);

    // flush with both stages valid and hold asserted on the same cycle
    present(64'h40, 64'h1, 1'b1, 7'd20);
    tick();
    present(64'h50, 64'h1, 1'b1, 7'd21);
    tick();
    check("flush_pre_vld", 64'(ex2_vld), 64'd1);
    ex0_vld = 1'b0;
    flush = 1'b1;
    ex2_hold = 1'b1;
    tick();
    flush = 1'b0;
    ex2_hold = 1'b0;
    check("flush_vld", 64'(ex2_vld), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("flush_after%0d", k), 64'(ex2_vld), 64'd0);
    end

    // flush beats accept of a presented op
    present(64'h60, 64'h1, 1'b1, 7'd22);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ex0_vld = 1'b0;
    tick();
    check("flush_acc", 64'(ex2_vld), 64'd0);

    // reset mid-op with both stages valid
    present(64'h70, 64'h1, 1'b1, 7'd30);
    tick();
    present(64'h80, 64'h1, 1'b1, 7'd31);
    tick();
    check("rstmid_pre_vld", 64'(ex2_vld), 64'd1);
    ex0_vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero_outputs("rstmid");
    tick();
    check("rstmid_drain", 64'(ex2_vld), 64'd0);
    run_op("post_rst", 64'h10, 64'h20, 1'b1, 7'd40, 64'h30, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
